electrode_actuation_sequencer: RTL and testbench
================================================

Name: electrode_actuation_sequencer

Overview:
Drives the move generator from its consuming end. It produces the generator's init, activate and `next` strobes, and samples the returned electrode addresses A1–A4 and `reachDest`. Each move is decoded into a 16-bit electrode-enable vector and held for a programmable dwell time. The block sits between the move generator and the electrode voltage drivers of the linear train-transport array. It paces every droplet-train move from src to dest.

Parameters:
- DWELL_CYCLES, 1000: clocks each decoded electrode pattern is held; must be at least 1.
- PULSE_CYCLES, 4: high width of each `next` pulse, and its following low width; must be at least 1.
- SETTLE_CYCLES, 2: clocks after the `next` falling edge before A1–A4 and `reachDest` are sampled.
- MAX_STEPS, 16: watchdog limit on moves per transfer.
- BLANK_CYCLES, 8: all-off gap between moves; used only with the optional feature.

Ports:
- clock, in, 1: single system clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-clock request to begin a transfer; ignored unless the state is IDLE or DONE.
- abort, in, 1: synchronous abort.
- dropletSelect, in, 1: 1 = 4-droplet train, 0 = 2-droplet train; latched on an accepted start.
- A1, A2, A3, A4, in, 4 each: electrode addresses from the generator.
- reachDest, in, 1: generator's destination-reached flag.
- gen_reset_N, out, 1: generator init-enable.
- gen_act_N, out, 1: generator move-enable.
- next, out, 1: generator step strobe; the generator acts on its falling edge.
- electrode, out, 16: electrode enables, bit i = electrode i.
- busy, out, 1: transfer in progress.
- done, out, 1: destination reached.
- error, out, 1: watchdog fired.
- step_count, out, 5: number of moves actuated in the current transfer.

Behaviour:
- Reset values: all outputs 0; state = IDLE; internal counters = 0.
- States: IDLE, INIT_HI, INIT_LO, STEP_HI, STEP_LO, SETTLE, CHECK, DWELL, DONE, ERR.
- IDLE: on start, latch dropletSelect, clear step_count, set busy = 1, go to INIT_HI.
- INIT_HI / INIT_LO:
  - gen_reset_N = 1, gen_act_N = 0.
  - next = 1 for PULSE_CYCLES, then next = 0 for PULSE_CYCLES.
  - The falling edge initialises the generator.
  - Then go to STEP_HI.
- STEP_HI / STEP_LO:
  - gen_reset_N = 0, gen_act_N = 1.
  - Same pulse shape as init.
  - Then go to SETTLE.
- SETTLE: wait SETTLE_CYCLES, then go to CHECK.
- CHECK (one clock):
  - reachDest = 1: go to DONE. electrode keeps its last pattern; no new decode.
  - Otherwise, if step_count == MAX_STEPS: go to ERR.
  - Otherwise: load electrode with the decoded mask, increment step_count, go to DWELL.
- Decoded mask:
  - Bits A1 and A2 are set.
  - A3 and A4 bits are added only if the latched dropletSelect = 1.
  - Duplicate addresses are OR-ed together.
  - Address values are used as-is; no range check. 4'hF is a valid electrode in 4-droplet mode.
- DWELL: hold electrode for DWELL_CYCLES, then go to STEP_HI.
- Latency: the first pattern is driven 2·PULSE_CYCLES·2 + SETTLE_CYCLES + 1 clocks after start is accepted.
- DONE:
  - done = 1, busy = 0; electrode is held so the train stays pinned.
  - start begins a new transfer and clears done and electrode on acceptance.
- ERR:
  - error = 1, electrode = 0, busy = 0.
  - Left only by reset or abort.
- Abort, in any state:
  - Next clock: electrode = 0, next = 0, gen_act_N = 0, gen_reset_N = 0, done = 0, error = 0, busy = 0, go to IDLE.
- Priority: reset > abort > start.
- start together with abort is ignored.
- A start pulse during a transfer is ignored (no queueing).
- next is always a registered output and has no glitches.
- The generator's own src ≥ dest case asserts reachDest immediately. The result is DONE with step_count = 0 and electrode = 0.

Optional Feature:
- Macro: ACTUATION_BLANK_EN.
- Defined: after DWELL, a BLANK state drives electrode = 0 for BLANK_CYCLES, then goes to STEP_HI. Abort during BLANK behaves as in any other state.
- Not defined: DWELL goes directly to STEP_HI; consecutive patterns are switched without a gap.

Decomposition:
- Shared package dmfb_pkg holds:
  - the state enum;
  - constant NUM_ELECTRODES = 16;
  - constant ADDR_W = 4;
  - the address-to-one-hot decode function.
- One sub-module, strobe_pulser: a counter-driven high/low pulse generator. It is reused for the init and step strobes and reports completion.

Test Plan:
1. Generator model; src=2, dest=5, dropletSelect=0 → electrode patterns 0x000C, 0x0018, 0x0030, each held DWELL_CYCLES. Then done=1, step_count=3, electrode held at 0x0030.
2. src=0, dest=3, dropletSelect=1 → single pattern 0x000F, then done=1, step_count=1.
3. src=6, dest=4 (generator forces reachDest) → done=1, step_count=0, electrode=0x0000.
4. Model that never asserts reachDest, MAX_STEPS=4 → four patterns, then error=1, electrode=0. A start pulse has no effect until abort.
5. abort pulsed mid-DWELL of the second move → next clock: electrode=0, busy=0, state IDLE. A following start restarts from INIT with step_count=0.
6. With ACTUATION_BLANK_EN defined, case 1 → electrode=0 for BLANK_CYCLES between each pattern. Also check: start while busy is ignored, and reset mid-STEP_HI returns all outputs to 0.

Source files
------------

// File: rtl/dmfb_pkg.sv
// Shared definitions for the droplet-transport electrode sequencer:
// array geometry, sequencer state encoding and the address decoder.
package dmfb_pkg;

    localparam int NUM_ELECTRODES = 16;
    localparam int ADDR_W         = 4;

    // Explicit encodings so the state register reads the same in every tool.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT_HI = 4'd1,
        ST_INIT_LO = 4'd2,
        ST_STEP_HI = 4'd3,
        ST_STEP_LO = 4'd4,
        ST_SETTLE  = 4'd5,
        ST_CHECK   = 4'd6,
        ST_DWELL   = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9,
        ST_BLANK   = 4'd10
    } state_e;

    // One electrode address to its one-hot enable; every 4-bit value is a real electrode.
    function automatic logic [NUM_ELECTRODES-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_ELECTRODES-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/electrode_actuation_sequencer_strobe_pulser.sv
// Counter-driven strobe: PULSE_CYCLES high then PULSE_CYCLES low after each
// launch. 'falling' marks the clock whose edge drops the strobe, 'complete'
// marks the last clock of the low phase. A launch on the completing clock
// starts the next pulse back-to-back.
module strobe_pulser #(
    parameter int PULSE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic launch,
    output logic pulse,
    output logic falling,
    output logic complete
);

    localparam int CW = (PULSE_CYCLES < 2) ? 1 : $clog2(PULSE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          active;
    logic          high_phase;
    logic          last;

    assign last     = (cnt == CNT_LAST);
    assign falling  = active & high_phase & last;
    assign complete = active & ~high_phase & last;

    // Phase counter; the strobe itself is a flop so it never glitches.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            pulse      <= 1'b0;
            cnt        <= '0;
        end else if (launch) begin
            active     <= 1'b1;
            high_phase <= 1'b1;
            pulse      <= 1'b1;
            cnt        <= '0;
        end else if (active) begin
            if (last) begin
                cnt <= '0;
                if (high_phase) begin
                    high_phase <= 1'b0;
                    pulse      <= 1'b0;
                end else begin
                    active <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/electrode_actuation_sequencer.sv
// Electrode actuation sequencer: steps the move generator with init/step
// strobes, decodes its returned addresses into a 16-electrode enable pattern
// and holds each pattern for DWELL_CYCLES. A watchdog stops a transfer after
// MAX_STEPS moves without reaching the destination.
// Build option ACTUATION_BLANK_EN: inserts an all-off gap of BLANK_CYCLES
// after each dwell before the next move is requested.
module electrode_actuation_sequencer
    import dmfb_pkg::*;
#(
    parameter int DWELL_CYCLES  = 1000,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 16,
    parameter int BLANK_CYCLES  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      dropletSelect,
    input  logic [ADDR_W-1:0]         A1,
    input  logic [ADDR_W-1:0]         A2,
    input  logic [ADDR_W-1:0]         A3,
    input  logic [ADDR_W-1:0]         A4,
    input  logic                      reachDest,
    output logic                      gen_reset_N,
    output logic                      gen_act_N,
    output logic                      next,
    output logic [NUM_ELECTRODES-1:0] electrode,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [4:0]                step_count
);

    // One shared timer serves SETTLE, DWELL and BLANK; size it for the longest.
    localparam int TMAX_A = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
    localparam int TMAX   = (TMAX_A > BLANK_CYCLES) ? TMAX_A : BLANK_CYCLES;
    localparam int TW     = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST  = TW'(BLANK_CYCLES - 1);
    localparam logic [4:0]    STEP_LIMIT  = 5'(MAX_STEPS);

    state_e                    state;
    state_e                    nxt;
    logic [TW-1:0]             tmr;
    logic                      sel_four;
    logic                      accept;
    logic                      launch;
    logic                      load;
    logic                      strobe_falling;
    logic                      strobe_complete;
    logic [NUM_ELECTRODES-1:0] mask;

    strobe_pulser #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulser (
        .clock    (clock),
        .reset    (reset),
        .clear    (abort),
        .launch   (launch),
        .pulse    (next),
        .falling  (strobe_falling),
        .complete (strobe_complete)
    );

    // Decode the generator's addresses; the rear pair only counts for a 4-droplet train.
    always_comb begin
        mask = addr_onehot(A1) | addr_onehot(A2);
        if (sel_four) begin
            mask = mask | addr_onehot(A3) | addr_onehot(A4);
        end
    end

    // Next-state logic; 'launch' fires the strobe on entry to INIT_HI/STEP_HI.
    always_comb begin
        nxt    = state;
        accept = 1'b0;
        launch = 1'b0;
        load   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept = 1'b1;
                    launch = 1'b1;
                    nxt    = ST_INIT_HI;
                end
            end
            ST_INIT_HI: begin
                if (strobe_falling) nxt = ST_INIT_LO;
            end
            ST_INIT_LO: begin
                if (strobe_complete) begin
                    launch = 1'b1;
                    nxt    = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                if (strobe_falling) nxt = ST_STEP_LO;
            end
            ST_STEP_LO: begin
                if (strobe_complete) begin
                    if (SETTLE_CYCLES > 0) nxt = ST_SETTLE;
                    else                   nxt = ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (tmr == SETTLE_LAST) nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (reachDest) begin
                    nxt = ST_DONE;
                end else if (step_count == STEP_LIMIT) begin
                    nxt = ST_ERR;
                end else begin
                    load = 1'b1;
                    nxt  = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (tmr == DWELL_LAST) begin
`ifdef ACTUATION_BLANK_EN
                    if (BLANK_CYCLES > 0) begin
                        nxt = ST_BLANK;
                    end else begin
                        launch = 1'b1;
                        nxt    = ST_STEP_HI;
                    end
`else
                    launch = 1'b1;
                    nxt    = ST_STEP_HI;
`endif
                end
            end
`ifdef ACTUATION_BLANK_EN
            ST_BLANK: begin
                if (tmr == BLANK_LAST) begin
                    launch = 1'b1;
                    nxt    = ST_STEP_HI;
                end
            end
`endif
            ST_ERR: begin
                nxt = ST_ERR;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
        // Abort wins over a same-clock start; keep the strobe from relaunching.
        if (abort) launch = 1'b0;
    end

    // State, timer, generator enables and the registered status/electrode outputs.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            sel_four    <= 1'b0;
            gen_reset_N <= 1'b0;
            gen_act_N   <= 1'b0;
            electrode   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            if (reset) step_count <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) tmr <= '0;
            else              tmr <= tmr + 1'b1;

            gen_reset_N <= (nxt == ST_INIT_HI) || (nxt == ST_INIT_LO);
            gen_act_N   <= (nxt == ST_STEP_HI) || (nxt == ST_STEP_LO);

            if (accept) begin
                sel_four   <= dropletSelect;
                step_count <= '0;
                busy       <= 1'b1;
                done       <= 1'b0;
                error      <= 1'b0;
                electrode  <= '0;
            end

            if (load) begin
                electrode  <= mask;
                step_count <= step_count + 1'b1;
            end

            // Destination reached: the last pattern stays on to pin the train.
            if (state == ST_CHECK && nxt == ST_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end

            if (state == ST_CHECK && nxt == ST_ERR) begin
                error     <= 1'b1;
                busy      <= 1'b0;
                electrode <= '0;
            end

`ifdef ACTUATION_BLANK_EN
            if (state == ST_DWELL && nxt == ST_BLANK) begin
                electrode <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_electrode_actuation_sequencer.sv
// Bench for electrode_actuation_sequencer with a behavioural move generator.
// Expected electrode patterns are queued when a transfer is launched and
// popped by a monitor whenever a new pattern appears on the electrodes.
module tb_electrode_actuation_sequencer;

    localparam int DWELL  = 6;
    localparam int PULSE  = 2;
    localparam int SETTLE = 2;
    localparam int MAXS   = 4;
    localparam int BLANK  = 3;
    localparam int LAT    = 2 * PULSE * 2 + SETTLE + 1;
`ifdef ACTUATION_BLANK_EN
    localparam int INTERVAL = DWELL + BLANK + 2 * PULSE + SETTLE + 1;
`else
    localparam int INTERVAL = DWELL + 2 * PULSE + SETTLE + 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dropletSelect = 1'b0;
    logic [3:0]  A1 = '0, A2 = '0, A3 = '0, A4 = '0;
    logic        reachDest = 1'b0;
    logic        gen_reset_N, gen_act_N, next, busy, done, error;
    logic [15:0] electrode;
    logic [4:0]  step_count;

    electrode_actuation_sequencer #(
        .DWELL_CYCLES  (DWELL),
        .PULSE_CYCLES  (PULSE),
        .SETTLE_CYCLES (SETTLE),
        .MAX_STEPS     (MAXS),
        .BLANK_CYCLES  (BLANK)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .dropletSelect (dropletSelect),
        .A1            (A1),
        .A2            (A2),
        .A3            (A3),
        .A4            (A4),
        .reachDest     (reachDest),
        .gen_reset_N   (gen_reset_N),
        .gen_act_N     (gen_act_N),
        .next          (next),
        .electrode     (electrode),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .step_count    (step_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Move generator: init on a falling 'next' with gen_reset_N, step with gen_act_N.
    int g_src = 0, g_dest = 0, g_len = 2, g_cur = 0;
    bit g_noreach = 1'b0, g_first = 1'b0, g_reach = 1'b0;
    logic next_q = 1'b0;

    always @(negedge clock) begin
        if (next_q && !next) begin
            if (gen_reset_N) begin
                g_cur   = g_src;
                g_first = 1'b1;
                g_reach = (g_src >= g_dest) && !g_noreach;
            end else if (gen_act_N) begin
                if (g_first) g_first = 1'b0;
                else if (!g_reach) begin
                    if (!g_noreach && (g_cur + g_len - 1 >= g_dest)) g_reach = 1'b1;
                    else g_cur++;
                end
            end
        end
        next_q    = next;
        A1        = 4'(g_cur);
        A2        = 4'(g_cur + 1);
        A3        = 4'(g_cur + 2);
        A4        = 4'(g_cur + 3);
        reachDest = g_reach;
    end

    // Scoreboard monitor.
    logic [15:0] exp_q[$];
    logic [15:0] prev_e = '0;
    int cyc = 0, last_load = 0, start_cyc = 0;
    bit first_pending = 1'b0;

    always @(posedge clock) begin
        #1;
        cyc++;
        if (electrode != prev_e && electrode != 16'h0) begin
            if (exp_q.size() == 0) chk("unexpected_pattern", 32'(electrode), 32'h0);
            else                   chk("pattern", 32'(electrode), 32'(exp_q.pop_front()));
            if (first_pending) chk("first_latency", 32'(cyc - start_cyc), 32'(LAT));
            else               chk("load_interval", 32'(cyc - last_load), 32'(INTERVAL));
            first_pending = 1'b0;
            last_load     = cyc;
        end
`ifdef ACTUATION_BLANK_EN
        if (electrode == 16'h0 && prev_e != 16'h0 && busy && !first_pending)
            chk("blank_after_dwell", 32'(cyc - last_load), 32'(DWELL));
`endif
        prev_e = electrode;
    end

    task automatic do_start(input bit sel, input bit expect_accept);
        @(negedge clock);
        dropletSelect = sel;
        start = 1'b1;
        if (expect_accept) begin
            start_cyc     = cyc + 1;
            first_pending = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int maxc);
        int n = 0;
        while (!(done || error) && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_finished"}, 32'(done || error), 32'h1);
    endtask

    task automatic wait_steps(input int k, input int maxc);
        int n = 0;
        while (int'(step_count) != k && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk("reach_step_count", 32'(step_count), 32'(k));
    endtask

    task automatic set_gen(input int s, input int d, input int len, input bit noreach);
        g_src = s; g_dest = d; g_len = len; g_noreach = noreach;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_electrode", 32'(electrode), 32'h0);
        chk("rst_flags", {26'h0, busy, done, error, next, gen_reset_N, gen_act_N}, 32'h0);
        chk("rst_step_count", 32'(step_count), 32'h0);

        // Case 1: 2-droplet, src=2 dest=5
        set_gen(2, 5, 2, 1'b0);
        exp_q.push_back(16'h000C); exp_q.push_back(16'h0018); exp_q.push_back(16'h0030);
        do_start(1'b0, 1'b1);
        chk("init_strobe", {29'h0, busy, next, gen_reset_N}, 32'h7);
        chk("init_act_low", 32'(gen_act_N), 32'h0);
        chk("start_step_count", 32'(step_count), 32'h0);
        wait_end("c1", 400);
        chk("c1_done", {29'h0, done, busy, error}, 32'h4);
        chk("c1_step_count", 32'(step_count), 32'd3);
        chk("c1_electrode", 32'(electrode), 32'h0030);
        chk("c1_queue_empty", 32'(exp_q.size()), 32'h0);
        repeat (10) @(negedge clock);
        chk("c1_pinned", 32'(electrode), 32'h0030);

        // Case 2: 4-droplet, src=0 dest=3
        set_gen(0, 3, 4, 1'b0);
        exp_q.push_back(16'h000F);
        do_start(1'b1, 1'b1);
        chk("c2_done_cleared", 32'(done), 32'h0);
        wait_end("c2", 400);
        chk("c2_done", 32'(done), 32'h1);
        chk("c2_step_count", 32'(step_count), 32'd1);
        chk("c2_electrode", 32'(electrode), 32'h000F);

        // Case 3: src beyond dest, immediate reachDest
        set_gen(6, 4, 2, 1'b0);
        do_start(1'b0, 1'b1);
        wait_end("c3", 400);
        chk("c3_done", 32'(done), 32'h1);
        chk("c3_step_count", 32'(step_count), 32'd0);
        chk("c3_electrode", 32'(electrode), 32'h0);

        // Case 4: watchdog
        set_gen(0, 15, 2, 1'b1);
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0006);
        exp_q.push_back(16'h000C); exp_q.push_back(16'h0018);
        do_start(1'b0, 1'b1);
        wait_end("c4", 600);
        chk("c4_error", {29'h0, error, done, busy}, 32'h4);
        chk("c4_electrode", 32'(electrode), 32'h0);
        chk("c4_step_count", 32'(step_count), 32'd4);
        do_start(1'b0, 1'b0);
        repeat (20) @(negedge clock);
        chk("c4_start_ignored", {29'h0, error, busy, next}, 32'h4);
        @(negedge clock); abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        chk("c4_abort_clears", 32'(error), 32'h0);
        set_gen(0, 15, 2, 1'b0);

        // start together with abort is ignored
        @(negedge clock); start = 1'b1; abort = 1'b1;
        @(negedge clock); start = 1'b0; abort = 1'b0;
        chk("start_with_abort", {30'h0, busy, next}, 32'h0);

        // Case 5: abort in the second dwell, then restart
        set_gen(2, 5, 2, 1'b0);
        exp_q.push_back(16'h000C); exp_q.push_back(16'h0018);
        do_start(1'b0, 1'b1);
        wait_steps(2, 200);
        repeat (2) @(negedge clock);
        abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        chk("c5_abort_electrode", 32'(electrode), 32'h0);
        chk("c5_abort_flags", {26'h0, busy, done, error, next, gen_reset_N, gen_act_N}, 32'h0);
        chk("c5_queue_empty", 32'(exp_q.size()), 32'h0);
        exp_q.push_back(16'h000C); exp_q.push_back(16'h0018); exp_q.push_back(16'h0030);
        do_start(1'b0, 1'b1);
        chk("c5_restart_count", 32'(step_count), 32'h0);
        chk("c5_restart_init", 32'(gen_reset_N), 32'h1);
        wait_steps(1, 200);
        do_start(1'b1, 1'b0);
        wait_end("c5", 400);
        chk("c5_step_count", 32'(step_count), 32'd3);
        chk("c5_electrode", 32'(electrode), 32'h0030);

        // Reset in the middle of STEP_HI
        set_gen(2, 9, 2, 1'b0);
        do_start(1'b0, 1'b1);
        begin
            int n = 0;
            while (!(gen_act_N && next) && n < 100) begin
                @(negedge clock);
                n++;
            end
        end
        chk("in_step_hi", {30'h0, gen_act_N, next}, 32'h3);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        chk("midrst_electrode", 32'(electrode), 32'h0);
        chk("midrst_flags", {26'h0, busy, done, error, next, gen_reset_N, gen_act_N}, 32'h0);
        chk("midrst_step_count", 32'(step_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
